ray_sampler: RTL

Downstream stage of ray generation. Accepts one ray per handshake, either a camera ray or an origin/direction pair in Q12.4. Emits N_SAMPLES evenly spaced 3-D sample points along it, one per cycle under valid/ready back-pressure. Each point is p_k = o + d·t_k with t_k = near + k·Δ. Points feed the positional-encoding / MLP stage.

---
 rtl/ray_sampler_if.sv | 29 ++
 rtl/ray_sampler.sv | 110 +++++++++++
 2 files changed

// File: rtl/ray_sampler_if.sv
// Ray-in / sample-point-out handshake bundle for ray_sampler.
// The master drives rays and consumes points; the slave is the sampler.
interface ray_sampler_if #(
  parameter int NTOTAL_BITS = 16,
  parameter int LOG2_N      = 6
);
  logic                     ray_valid;
  logic                     ray_ready;
  logic [3*NTOTAL_BITS-1:0] rays_o;
  logic [3*NTOTAL_BITS-1:0] rays_d;
  logic [NTOTAL_BITS-1:0]   near;
  logic [NTOTAL_BITS-1:0]   far;
  logic                     pt_valid;
  logic                     pt_ready;
  logic [3*NTOTAL_BITS-1:0] pt;
  logic [NTOTAL_BITS-1:0]   pt_t;
  logic [LOG2_N-1:0]        pt_idx;
  logic                     pt_last;

  modport master (
    output ray_valid, rays_o, rays_d, near, far, pt_ready,
    input  ray_ready, pt_valid, pt, pt_t, pt_idx, pt_last
  );

  modport slave (
    input  ray_valid, rays_o, rays_d, near, far, pt_ready,
    output ray_ready, pt_valid, pt, pt_t, pt_idx, pt_last
  );
endinterface

// File: rtl/ray_sampler.sv
// Emits 2^LOG2_N evenly spaced fixed-point points p_k = o + d*t_k along one
// accepted ray, one per cycle under valid/ready back-pressure.
module ray_sampler #(
  parameter int NTOTAL_BITS = 16,
  parameter int NFRAC_BITS  = 4,
  parameter int LOG2_N      = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  ray_sampler_if.slave bus
);
  localparam int W = NTOTAL_BITS;

  typedef enum logic {IDLE, RUN} state_e;
  typedef logic signed [W-1:0] word_t;

  state_e            state_q;
  logic [3*W-1:0]    o_q;
  logic [3*W-1:0]    d_q;
  word_t             delta_q;
  word_t             t_q;
  logic [LOG2_N-1:0] k_q;
  logic              pt_valid_q;
  logic [3*W-1:0]    pt_q;
  word_t             pt_t_q;
  logic [LOG2_N-1:0] pt_idx_q;
  logic              pt_last_q;

  logic              load;
  logic              k_last;
  word_t             span_d;
  logic [3*W-1:0]    pt_d;

  // Full-width signed product, keep the Q-format window; high bits wrap away.
  function automatic word_t mul(input word_t a, input word_t b);
    logic signed [2*W-1:0] p;
    p = a * b;
    return p[W+NFRAC_BITS-1:NFRAC_BITS];
  endfunction

  assign load   = (state_q == RUN) && (!pt_valid_q || bus.pt_ready);
  assign k_last = &k_q;
  assign span_d = word_t'(bus.far - bus.near);

  // NOTE: combinational blocks assign a default before any conditional
  // update, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    pt_d = '0;
    for (int i = 0; i < 3; i++) begin
      pt_d[i*W +: W] = o_q[i*W +: W] + mul(d_q[i*W +: W], t_q);
    end
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      o_q        <= '0;
      d_q        <= '0;
      delta_q    <= '0;
      t_q        <= '0;
      k_q        <= '0;
      pt_valid_q <= 1'b0;
      pt_q       <= '0;
      pt_t_q     <= '0;
      pt_idx_q   <= '0;
      pt_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ray_valid) begin
            o_q     <= bus.rays_o;
            d_q     <= bus.rays_d;
            t_q     <= bus.near;
            k_q     <= '0;
            delta_q <= span_d >>> LOG2_N;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (load) begin
            pt_q      <= pt_d;
            pt_t_q    <= t_q;
            pt_idx_q  <= k_q;
            pt_last_q <= k_last;
            t_q       <= t_q + delta_q;
            k_q       <= k_q + 1'b1;
            state_q   <= k_last ? IDLE : RUN;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A point waiting without pt_ready is held; a taken point clears valid.
      if (load) begin
        pt_valid_q <= 1'b1;
      end else if (bus.pt_ready) begin
        pt_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ray_ready = (state_q == IDLE);
  assign bus.pt_valid  = pt_valid_q;
  assign bus.pt        = pt_q;
  assign bus.pt_t      = pt_t_q;
  assign bus.pt_idx    = pt_idx_q;
  assign bus.pt_last   = pt_last_q;
endmodule
